// File: rtl/uart_sync_fifo_128x8.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo_128x8
// Single-clock byte FIFO used on the UART TX and RX data paths. It is a ring
// buffer over a 128x8 memory, with a registered RAM read address, an
// occupancy counter and full/empty/threshold flags.
//
// Ports
//   clock     in   1           single clock, all logic on rising edge
//   reset_n   in   1           asynchronous active-low reset
//   data_in   in   FIFO_WIDTH  write data
//   read_n    in   1           pop strobe, active low, one pop per low cycle
//   write_n   in   1           push strobe, active low, one push per low cycle
//   level     in   FIFO_BITS   threshold for the half flag
//   data_out  out  FIFO_WIDTH  registered read data
//   full      out  1           occupancy == FIFO_DEPTH-1
//   empty     out  1           occupancy == 0
//   half      out  1           occupancy >= level (unsigned)
//
// Usable capacity is FIFO_DEPTH-1. There is no overflow or underflow
// protection: the counter simply wraps, so callers must honour full/empty.
// ---------------------------------------------------------------------------
module uart_sync_fifo_128x8 #(
  parameter int FIFO_DEPTH = 128,
  parameter int FIFO_BITS  = 7,
  parameter int FIFO_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [FIFO_BITS-1:0]  level,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  half
);

  logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [FIFO_BITS-1:0]  wr_ptr_r;
  logic [FIFO_BITS-1:0]  rd_ptr_r;
  logic [FIFO_BITS-1:0]  count_r;
  logic [FIFO_BITS-1:0]  addr_r;
  logic                  rd_hold_r;
  logic [FIFO_WIDTH-1:0] data_out_r;
  logic [FIFO_WIDTH-1:0] ram_q_s;
  logic                  wr_s;
  logic                  rd_s;

  localparam logic [FIFO_BITS-1:0] FULL_COUNT = FIFO_BITS'(FIFO_DEPTH - 1);

  assign wr_s = ~write_n;
  assign rd_s = ~read_n;

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Read port is combinational from the array, so a write landing on the
  // registered address shows through on the following cycle.
  assign ram_q_s = mem_r[addr_r];

  // Pointers, occupancy counter and the registered RAM read address.
  // Pointer wrap 127->0 falls out of the FIFO_BITS-wide arithmetic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {FIFO_BITS{1'b0}};
      rd_ptr_r <= {FIFO_BITS{1'b0}};
      count_r  <= {FIFO_BITS{1'b0}};
      addr_r   <= {FIFO_BITS{1'b0}};
    end else begin
      addr_r <= rd_ptr_r;
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_BITS'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_BITS'(1);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + FIFO_BITS'(1);
        2'b01:   count_r <= count_r - FIFO_BITS'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output stage: rd_hold remembers that the previous edge was a pop, so the
  // byte addressed at that edge is captured one cycle later and then held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_hold_r  <= 1'b0;
      data_out_r <= {FIFO_WIDTH{1'b0}};
    end else begin
      rd_hold_r <= read_n;
      if (!rd_hold_r) begin
        data_out_r <= ram_q_s;
      end
    end
  end

  assign data_out = data_out_r;
  assign full     = (count_r == FULL_COUNT);
  assign empty    = (count_r == {FIFO_BITS{1'b0}});
  assign half     = (count_r >= level);

endmodule

// File: tb/tb_uart_sync_fifo_128x8.sv
// ---------------------------------------------------------------------------
// tb_uart_sync_fifo_128x8
// Self-checking bench: a queue models FIFO contents, a one-deep pending slot
// models the one-cycle read latency, and flags are derived from queue size.
// ---------------------------------------------------------------------------
module tb_uart_sync_fifo_128x8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       read_n;
  logic       write_n;
  logic [6:0] level;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       half;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic [7:0] exp_data;
  logic [7:0] pend;
  bit         exp_valid;
  bit         pend_valid;

  always #5 clock = ~clock;

  uart_sync_fifo_128x8 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .read_n   (read_n),
    .write_n  (write_n),
    .level    (level),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .half     (half)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flags();
    chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("full",  {31'd0, full},  {31'd0, q.size() == 127});
    chk("half",  {31'd0, half},  {31'd0, q.size() >= int'(level)});
  endtask

  // One clock cycle: drive at negedge, model at posedge, check at next negedge.
  task automatic step(input bit wr, input bit rd, input logic [7:0] d);
    write_n = ~wr;
    read_n  = ~rd;
    data_in = d;
    @(posedge clock);
    if (pend_valid) begin
      exp_data  = pend;
      exp_valid = 1'b1;
    end
    pend_valid = 1'b0;
    if (rd) begin
      pend       = q.pop_front();
      pend_valid = 1'b1;
    end
    if (wr) q.push_back(d);
    @(negedge clock);
    write_n = 1'b1;
    read_n  = 1'b1;
    check_flags();
    if (exp_valid) chk("data_out", {24'd0, data_out}, {24'd0, exp_data});
  endtask

  task automatic model_reset();
    q.delete();
    pend_valid = 1'b0;
    exp_valid  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    read_n  = 1'b1;
    write_n = 1'b1;
    data_in = 8'h00;
    level   = 7'd0;
    model_reset();

    // Reset state
    #1;
    chk("rst_half_lvl0", {31'd0, half}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_dout", {24'd0, data_out}, 32'd0);
    level = 7'd7;
    #1;
    chk("rst_half_lvl7", {31'd0, half}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("dout_before_edge", {24'd0, data_out}, 32'd0);
    @(negedge clock);

    // Three bytes in, three out
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("dout_11", {24'd0, data_out}, 32'h11);
    step(1'b0, 1'b1, 8'h00);
    chk("dout_22", {24'd0, data_out}, 32'h22);
    chk("empty_after_3", {31'd0, empty}, 32'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("dout_33", {24'd0, data_out}, 32'h33);

    // Fill to 127, half threshold at 64
    level = 7'd64;
    for (int i = 0; i < 127; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 62) chk("half_lo_63", {31'd0, half}, 32'd0);
      if (i == 63) chk("half_hi_64", {31'd0, half}, 32'd1);
    end
    chk("full_127", {31'd0, full}, 32'd1);
    for (int i = 0; i < 127; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("drain_last", {24'd0, data_out}, 32'd126);

    // Fill 100, then 50 cycles of simultaneous read+write across the wrap
    level = 7'd100;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 50; i++) begin
      level = (i % 2 == 0) ? 7'd100 : 7'd101;
      step(1'b1, 1'b1, 8'($urandom));
    end
    chk("count_100", q.size(), 32'd100);
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Randomized traffic honouring full/empty
    for (int i = 0; i < 400; i++) begin
      bit wr;
      bit rd;
      level = 7'($urandom_range(0, 127));
      wr = ($urandom_range(0, 1) == 1) && (q.size() < 127);
      rd = ($urandom_range(0, 1) == 1) && (q.size() > 0);
      step(wr, rd, 8'($urandom));
    end

    // Reset mid-stream at count 40
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'($urandom));
    level = 7'd3;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_full", {31'd0, full}, 32'd0);
    chk("mid_rst_half", {31'd0, half}, 32'd0);
    chk("mid_rst_dout", {24'd0, data_out}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("a5_after_rst", {24'd0, data_out}, 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
